mul_sequencer: RTL
==================

# mul_sequencer

Multi-cycle sequencer for the MIPS `mul` instruction (OpCode 011100, Function 000010). It stalls the pipeline, runs a 32-step shift-add multiply, and returns the low 32 bits of the product. It sits beside the single-cycle ALU in the EX stage, and the hazard/stall logic ORs its `Stall` into the pipeline freeze. All other opcodes pass through untouched: the sequencer stays idle and never stalls for them.

## Interface
- `WIDTH`, 32, operand and result width
- `Clk`  in  1  rising-edge clock
- `Reset`  in  1  synchronous, active-high reset
- `Issue`  in  1  EX-stage instruction valid
- `OpCode`  in  6  EX-stage opcode
- `Function`  in  6  EX-stage funct field
- `Flush`  in  1  abort current operation (branch mispredict / exception)
- `A`  in  WIDTH  multiplicand (rs value)
- `B`  in  WIDTH  multiplier (rt value)
- `Stall`  out  1  freeze IF/ID/EX, combinational
- `Busy`  out  1  state is RUN, registered
- `Done`  out  1  one-cycle pulse, `Result` valid
- `Result`  out  WIDTH  low WIDTH bits of A*B, registered

## Operation
- `IsMul = Issue & OpCode==011100 & Function==000010`.
- State machine with three states, IDLE, RUN and DONE:
  - IDLE→RUN when `IsMul & !Flush`. On that edge: load `mcand`←A, `mplier`←B, `acc`←0, `count`←0.
  - RUN, each cycle:
    - if `mplier[0]`, `acc`←`acc + mcand` (mod 2^WIDTH)
    - `mcand`←`mcand<<1`
    - `mplier`←`mplier>>1` (logical)
    - `count`++
  - RUN→DONE after the step with `count==WIDTH-1`, i.e. WIDTH RUN cycles. On that edge, `Result`←final `acc`.
  - DONE→IDLE unconditionally. `Issue` is ignored in DONE because the same `mul` is still presented.
- Signed and unsigned operands need no sign handling, because the low WIDTH bits are identical.
- `Stall = (IDLE & IsMul & !Flush) | RUN`. `Stall` is 0 in DONE, so the pipeline advances with `Result`.
- `Done` = 1 exactly in DONE.
- `Result` holds its value until the next DONE.
- `Flush` in RUN or DONE forces IDLE next cycle. It causes no `Done` pulse and leaves `Result` unchanged.
- `Reset` forces IDLE, `acc`/`mcand`/`mplier`/`count`/`Result` = 0 and `Busy`=`Done`=0. It takes effect from any state, including mid-RUN.
- Non-`mul` instructions cause no state change.

## Timing
- Reset values: `Stall`=0 (given `Issue`=0), `Busy`=0, `Done`=0, `Result`=0.
- Acceptance edge is T0.
- RUN occupies cycles T0+1 … T0+WIDTH.
- DONE is cycle T0+WIDTH+1. `Done`=1 there and `Result` is valid.
- Fixed latency is WIDTH+1 cycles from acceptance to `Done`.
- `Stall` is high from the issue cycle through T0+WIDTH inclusive.
- Back-to-back `mul`: the second `mul` arrives at EX the cycle after DONE and is accepted from IDLE. That gives a minimum spacing of WIDTH+2 cycles.
- `Flush` and `IsMul` in the same IDLE cycle: `Flush` wins, there is no acceptance and `Stall`=0.

## Configuration
- Macro: `MUL_SEQ_EARLY_EXIT_EN`.
- Defined:
  - RUN also exits to DONE after any step whose next `mplier` value (`mplier>>1`) is 0.
  - The RUN length becomes max(1, index of highest set bit of B + 1).
  - B=0 gives 1 RUN cycle, and `Result`=0.
- Undefined: RUN is always exactly WIDTH cycles.
- In both cases: the `Stall`/`Done` protocol is unchanged, and the product is identical.

## Structure
- Shared package `mips_pkg`:
  - `OP_SPECIAL2`=011100, `FN_MUL`=000010
  - the state enum `mul_state_t` {IDLE, RUN, DONE}
  - `WIDTH` default constant
- Sub-module `mul_shift_add_dp` holds the datapath registers (`mcand`, `mplier`, `acc`) and the adder.
  - It is driven by `load`/`step` strobes from the `mul_sequencer` FSM.
  - It exports `mplier_next_zero`.
- `count` and the FSM stay in `mul_sequencer`.

## Test plan
- Reset held 2 cycles, then released with `Issue`=0 → `Stall`=0, `Busy`=0, `Done`=0, `Result`=0.
- Accept `mul`, A=7, B=6 → `Stall` high for 33 cycles from issue; `Done` pulses one cycle at T0+33 with `Result`=42; `Issue` still high in DONE causes no restart.
- A=0xFFFFFFFD (−3), B=5 → `Result`=0xFFFFFFF1. A=0x00010000, B=0x00010000 → `Result`=0x00000000.
- ADD (OpCode 000000, Function 100000) and LW (100011) issued → `Stall`=0, `Busy` stays 0, `Result` unchanged.
- `Flush` at T0+10 of A=9, B=9 → IDLE at T0+11, no `Done`, `Result` keeps its prior 42. `Reset` at T0+5 → all outputs 0 next cycle.
- With `MUL_SEQ_EARLY_EXIT_EN`:
  - B=6 → 3 RUN cycles, `Done` at T0+4, `Result`=A*6.
  - B=0 → `Done` at T0+2, `Result`=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage definitions: opcode/funct encodings, multiplier FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: OP_SPECIAL2, FN_MUL, WIDTH_DEFAULT, mul_state_t, is_mul_instr().
package mips_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] FN_MUL      = 6'b000010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // True when the EX-stage instruction is a valid SPECIAL2 mul.
  function automatic logic is_mul_instr(input logic       issue,
                                        input logic [5:0] opcode,
                                        input logic [5:0] funct);
    return issue && (opcode == OP_SPECIAL2) && (funct == FN_MUL);
  endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: multiplicand, multiplier and accumulator registers.
// Latency: one step per cycle while step=1; load takes one cycle.
// Backpressure: none; purely strobe-driven by the sequencer FSM.
// Ports: clk, reset (sync, active-high), load/step strobes, a/b operands,
//        acc_next (accumulator after the current step), mplier_next_zero.
module mul_shift_add_dp
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_next,
  output logic             mplier_next_zero
);

  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q,    acc_d;

  always_comb begin
    // Sum wraps mod 2^WIDTH; only the low half of the product is kept.
    acc_next         = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    // After this step's shift the multiplier holds no more set bits.
    mplier_next_zero = (mplier_q >> 1) == '0;

    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (load) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
    end else if (step) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = acc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle MIPS mul sequencer: stalls the pipeline and returns low WIDTH bits of A*B.
// Latency: WIDTH+1 cycles acceptance-to-Done (shorter with MUL_SEQ_EARLY_EXIT_EN).
// Backpressure: drives Stall (combinational) to freeze IF/ID/EX from issue through last RUN cycle.
// Ports: Clk, Reset (sync, active-high), Issue/OpCode/Function (EX instr), Flush,
//        A/B operands; outputs Stall, Busy (registered), Done (1-cycle pulse), Result.
// Build option: define MUL_SEQ_EARLY_EXIT_EN to leave RUN once the multiplier runs out of set bits.
module mul_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Issue,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       Function,
  input  logic             Flush,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Stall,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

`ifdef MUL_SEQ_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  mul_state_t       state_q,  state_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic             is_mul;
  logic             accept;
  logic             step;
  logic             last_step;
  logic [WIDTH-1:0] acc_next;
  logic             mplier_next_zero;

  always_comb begin
    is_mul    = is_mul_instr(Issue, OpCode, Function);
    // Flush beats a same-cycle mul: no acceptance, no stall.
    accept    = (state_q == IDLE) && is_mul && !Flush;
    step      = (state_q == RUN) && !Flush;
    last_step = (count_q == LAST_COUNT) || (EARLY_EXIT && mplier_next_zero);

    state_d  = state_q;
    count_d  = count_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          count_d = '0;
        end
      end
      RUN: begin
        if (Flush) begin
          state_d = IDLE;
        end else begin
          count_d = count_q + CW'(1);
          if (last_step) begin
            state_d  = DONE;
            result_d = acc_next;
          end
        end
      end
      // The same mul is still presented in DONE, so Issue is ignored here.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);

    Stall  = accept || (state_q == RUN);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;

  mul_shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk              (Clk),
    .reset            (Reset),
    .load             (accept),
    .step             (step),
    .a                (A),
    .b                (B),
    .acc_next         (acc_next),
    .mplier_next_zero (mplier_next_zero)
  );

endmodule
